// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - fixed-latency single-word responder for the dram_cs/dram_nwait bus
module dram_responder #(
    parameter int    ADDR_W    = 16,
    parameter int    LATENCY   = 4,
    parameter int    CNT_W     = 16,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dram_cs,
    input  logic             dram_we,
    input  logic [31:0]      dram_addr,
    input  logic [31:0]      dram_din,
    output logic [31:0]      dram_dout,
    output logic             dram_nwait,
    output logic             err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_next;
    logic [4:0]          cnt;
    logic                we_q;
    logic                oor_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         din_q;
    logic                accept;
    logic                finish;
    logic [31:0]         mem [0:(1 << ADDR_W) - 1];

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (dram_cs) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 5'd1) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dram_nwait = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            idx_q     <= '0;
            din_q     <= '0;
            dram_dout <= '0;
            err       <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (accept) begin
                we_q  <= dram_we;
                idx_q <= dram_addr[ADDR_W+1:2];
                din_q <= dram_din;
                oor_q <= |dram_addr[31:ADDR_W+2];
                cnt   <= 5'(LATENCY - 1);
                if (|dram_addr[31:ADDR_W+2]) err <= 1'b1;
            end else if (state == BUSY) begin
                cnt <= cnt - 5'd1;
                // a strobe while busy is a protocol violation; the in-flight command is untouched
                if (dram_cs) err <= 1'b1;
            end
            if (finish) begin
                if (we_q) begin
                    if (wr_count != '1) wr_count <= wr_count + CNT_ONE;
                end else begin
                    if (rd_count != '1) rd_count <= rd_count + CNT_ONE;
                    dram_dout <= oor_q ? 32'h0 : mem[idx_q];
                end
            end
        end
    end

    // Kept free of reset so the array maps onto block RAM; reset only blocks the commit.
    always_ff @(posedge clk) begin
        if (rst_n && finish && we_q && !oor_q) mem[idx_q] <= din_q;
    end

endmodule
